// File: rtl/led_pattern_monitor.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_monitor
// Purpose  : Receive-side checker for the 26-bit running-light LED bus.
//            Classifies frame changes, locks onto a pattern mode and flags
//            deviations. Define LED_ORDER_CHECK_EN for strict fill/symmetric
//            ordering.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 16,
  parameter int ERR_W    = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [25:0]      led_in,
  output logic [1:0]       mode_out,
  output logic             locked,
  output logic             err_pulse,
  output logic             restart_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] CLS_A       = 2'd0;
  localparam logic [1:0] CLS_F       = 2'd1;
  localparam logic [1:0] CLS_S       = 2'd2;
  localparam logic [1:0] CLS_R       = 2'd3;
  localparam logic [4:0] GAP_MAX     = 5'd31;
  localparam logic [4:0] TIMEOUT_GAP = 5'(TIMEOUT);
  localparam logic [3:0] LOCK_N      = 4'(LOCK_CNT);

  state_t      state, state_nx;
  logic [1:0]  cls, cls_nx, cls_in, mode_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [25:0] prev, diff;
  logic [4:0]  gap, gap_nx;
  logic        changed, stall, err_nx, restart_nx;
  logic        upper_zero, f_shape, s_shape, f_order, s_order;
  logic        is_a, is_f, is_s, is_r, valid;

  // Mirrored LED pair (i, 7-i) used by the symmetric pattern.
  function automatic logic [7:0] pair_mask(input logic [1:0] i);
    pair_mask = (8'h01 << i) | (8'h80 >> i);
  endfunction

  assign diff    = prev ^ led_in;
  assign changed = (diff != 26'd0);

`ifdef LED_ORDER_CHECK_EN
  logic [3:0] fill_pos;
  logic [2:0] set_pairs;
  logic [1:0] outer_pair;
  logic       any_pair, sets_bits;

  always_comb begin
    fill_pos   = 4'd0;
    set_pairs  = 3'd0;
    outer_pair = 2'd0;
    any_pair   = 1'b0;
    for (int k = 0; k < 8; k++) fill_pos = fill_pos + {3'b000, prev[k]};
    // Descending scan leaves the outermost (lowest index) set pair last.
    for (int k = 3; k >= 0; k--) begin
      if (prev[k] && prev[7-k]) begin
        set_pairs  = set_pairs + 3'd1;
        outer_pair = 2'(k);
        any_pair   = 1'b1;
      end
    end
    sets_bits = ((led_in[7:0] & diff[7:0]) == diff[7:0]);
    f_order = sets_bits ? ((fill_pos < 4'd8) && (diff[7:0] == (8'h01 << fill_pos[2:0])))
                        : (diff[7:0] == (prev[7:0] & (~prev[7:0] + 8'h01)));
    s_order = sets_bits ? ((set_pairs < 3'd4) && (diff[7:0] == pair_mask(set_pairs[1:0])))
                        : (any_pair && ((prev[7:0] & diff[7:0]) == diff[7:0])
                           && (diff[7:0] == pair_mask(outer_pair)));
  end
`else
  assign f_order = 1'b1;
  assign s_order = 1'b1;
`endif

  always_comb begin
    upper_zero = (led_in[25:8] == 18'd0) && (diff[25:8] == 18'd0);
    f_shape    = upper_zero && (diff[7:0] != 8'h00)
                 && ((diff[7:0] & (diff[7:0] - 8'h01)) == 8'h00);
    s_shape    = 1'b0;
    for (int i = 0; i < 4; i++)
      if (upper_zero && (diff[7:0] == pair_mask(2'(i)))) s_shape = 1'b1;
    is_a = (led_in[25:8] == 18'd0) && ((led_in[7:0] == 8'h55) || (led_in[7:0] == 8'hAA))
           && ((prev[7:0] == ~led_in[7:0]) || (prev[7:0] == 8'h00)) && (gap == 5'd2);
    is_f = f_shape && f_order && (gap == 5'd8);
    is_s = s_shape && s_order && (gap == 5'd4);
    is_r = (led_in != 26'd0) && ((led_in & (led_in - 26'd1)) == 26'd0) && (gap == 5'd1);
    valid = is_a | is_f | is_s | is_r;
    cls_in = is_r ? CLS_R : is_s ? CLS_S : is_f ? CLS_F : CLS_A;
  end

  // The generator parks on 26'h1 between random frames; that stall is not a gap.
  assign stall = (led_in == 26'd1) && (cls == CLS_R)
                 && ((state == S_TRACK) || (state == S_LOCKED));

  always_comb begin
    state_nx   = state;
    cls_nx     = cls;
    cnt_nx     = cnt;
    mode_nx    = mode_out;
    err_nx     = 1'b0;
    restart_nx = 1'b0;
    gap_nx     = gap;
    if (changed) begin
      gap_nx = 5'd1;
      if ((led_in == 26'd0) && !is_f && !is_s) begin
        restart_nx = 1'b1;
        state_nx   = S_HUNT;
      end else begin
        case (state)
          S_HUNT: begin
            if (valid) begin
              state_nx = S_TRACK;
              cls_nx   = cls_in;
              cnt_nx   = 4'd1;
            end
          end
          S_TRACK: begin
            if (!valid) begin
              state_nx = S_HUNT;
            end else if (cls_in == cls) begin
              cnt_nx = cnt + 4'd1;
            end else begin
              cls_nx = cls_in;
              cnt_nx = 4'd1;
            end
          end
          S_LOCKED: begin
            if (!valid || (cls_in != cls)) begin
              err_nx   = 1'b1;
              state_nx = valid ? S_TRACK : S_HUNT;
              cls_nx   = valid ? cls_in : cls;
              cnt_nx   = 4'd1;
            end
          end
          default: state_nx = S_HUNT;
        endcase
      end
      if ((state_nx == S_TRACK) && (cnt_nx >= LOCK_N)) begin
        state_nx = S_LOCKED;
        mode_nx  = cls_nx;
      end
    end else begin
      if (!stall && (gap != GAP_MAX)) gap_nx = gap + 5'd1;
      if ((state == S_LOCKED) && (gap == TIMEOUT_GAP)) begin
        err_nx   = 1'b1;
        state_nx = S_HUNT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prev          <= 26'd0;
      gap           <= 5'd1;
      state         <= S_HUNT;
      cls           <= CLS_A;
      cnt           <= 4'd0;
      mode_out      <= 2'd0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      restart_pulse <= 1'b0;
      err_count     <= '0;
    end else begin
      if (changed) prev <= led_in;
      gap           <= gap_nx;
      state         <= state_nx;
      cls           <= cls_nx;
      cnt           <= cnt_nx;
      mode_out      <= mode_nx;
      locked        <= (state_nx == S_LOCKED);
      err_pulse     <= err_nx;
      restart_pulse <= restart_nx;
      if (err_nx && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_monitor
// Purpose  : Directed self-checking bench for led_pattern_monitor with a
//            run-length reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_monitor;

  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 16;
  localparam int ERR_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [25:0]      led_in = 26'd0;
  logic [1:0]       mode_out;
  logic             locked, err_pulse, restart_pulse;
  logic [ERR_W-1:0] err_count;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  led_pattern_monitor #(.LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .Clk(clk), .Rst(rst), .led_in(led_in), .mode_out(mode_out), .locked(locked),
    .err_pulse(err_pulse), .restart_pulse(restart_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a class per change and a run length of consecutive
  // same-class changes; the monitor is locked whenever the run reaches LOCK_CNT.
  logic [25:0] m_prev = 26'd0;
  int          m_gap = 1, m_run = 0, m_cls = -1;
  logic [1:0]  exp_mode = 2'd0;
  logic        exp_locked = 1'b0, exp_err = 1'b0, exp_rp = 1'b0;
  int          exp_cnt = 0;

  function automatic int classify(input logic [25:0] p, input logic [25:0] n, input int t);
    logic [25:0] d;
    d = p ^ n;
    if (n[25:8] == 0 && (n[7:0] == 8'h55 || n[7:0] == 8'hAA)
        && (p[7:0] == ~n[7:0] || p[7:0] == 8'h00) && t == 2) return 0;
    if (n[25:8] == 0 && d[25:8] == 0 && $countones(d) == 1 && t == 8) return 1;
    for (int i = 0; i < 4; i++)
      if (n[25:8] == 0 && d == ((26'd1 << i) | (26'd1 << (7 - i))) && t == 4) return 2;
    if ($countones(n) == 1 && t == 1) return 3;
    return -1;
  endfunction

  always @(posedge clk) begin
    int  c;
    bit  was_locked, stall;
    if (rst) begin
      m_prev = 26'd0; m_gap = 1; m_run = 0; m_cls = -1;
      exp_mode = 2'd0; exp_locked = 1'b0; exp_err = 1'b0; exp_rp = 1'b0; exp_cnt = 0;
    end else begin
      exp_err = 1'b0;
      exp_rp  = 1'b0;
      was_locked = (m_run >= LOCK_CNT);
      if (led_in != m_prev) begin
        c = classify(m_prev, led_in, m_gap);
        if (led_in == 26'd0 && c != 1 && c != 2) begin
          exp_rp = 1'b1;
          m_run  = 0;
        end else if (c < 0) begin
          exp_err = was_locked;
          m_run   = 0;
        end else if (c == m_cls && m_run > 0) begin
          if (m_run < 1000) m_run++;
        end else begin
          exp_err = was_locked;
          m_cls   = c;
          m_run   = 1;
        end
        m_prev = led_in;
        m_gap  = 1;
      end else begin
        stall = (led_in == 26'd1) && (m_run > 0) && (m_cls == 3);
        if (was_locked && m_gap == TIMEOUT) begin
          exp_err = 1'b1;
          m_run   = 0;
        end
        if (!stall && m_gap < 31) m_gap++;
      end
      if (m_run >= LOCK_CNT) exp_mode = 2'(m_cls);
      exp_locked = (m_run >= LOCK_CNT);
      if (exp_err && exp_cnt < 255) exp_cnt++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_mode_out", 32'(mode_out), 32'(exp_mode));
      chk("cyc_locked", 32'(locked), 32'(exp_locked));
      chk("cyc_err_pulse", 32'(err_pulse), 32'(exp_err));
      chk("cyc_restart_pulse", 32'(restart_pulse), 32'(exp_rp));
      chk("cyc_err_count", 32'(err_count), 32'(exp_cnt));
    end
  end

  // Called on a negedge: the frame is sampled at the next posedge and held
  // so the following frame arrives 'hold' edges later.
  task automatic frame(input logic [25:0] v, input int hold);
    led_in = v;
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    led_in = 26'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    logic [25:0] onehot [11];
    int          holds  [11];

    @(negedge clk);
    do_reset();
    checking = 1'b1;
    chk("rst_mode", 32'(mode_out), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_restart", 32'(restart_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    // Alternate: four T=2 changes lock in mode 00.
    frame(26'h0, 1);
    frame(26'h55, 2);
    frame(26'hAA, 2);
    frame(26'h55, 2);
    chk("alt_not_yet_locked", 32'(locked), 32'd0);
    frame(26'hAA, 1);
    chk("alt_locked", 32'(locked), 32'd1);
    chk("alt_mode", 32'(mode_out), 32'd0);
    chk("alt_err_count", 32'(err_count), 32'd0);
    @(negedge clk);

    // Deviation while locked, then restart frame.
    frame(26'h57, 1);
    chk("dev_err_pulse", 32'(err_pulse), 32'd1);
    chk("dev_err_count", 32'(err_count), 32'd1);
    chk("dev_unlocked", 32'(locked), 32'd0);
    frame(26'h57, 3);
    chk("dev_pulse_single", 32'(err_pulse), 32'd0);
    frame(26'h0, 1);
    chk("restart_pulse", 32'(restart_pulse), 32'd1);
    chk("restart_no_err", 32'(err_count), 32'd1);

    // Relock on alternate, then stall to hit the timeout.
    frame(26'h0, 1);
    frame(26'h55, 2);
    frame(26'hAA, 2);
    frame(26'h55, 2);
    frame(26'hAA, 16);
    chk("to_before", 32'(err_pulse), 32'd0);
    chk("to_still_locked", 32'(locked), 32'd1);
    frame(26'hAA, 1);
    chk("to_err_pulse", 32'(err_pulse), 32'd1);
    chk("to_unlocked", 32'(locked), 32'd0);
    chk("to_err_count", 32'(err_count), 32'd2);
    frame(26'hAA, 4);

    // Fill then drain every 8 cycles; the final 0x00 is a drain step.
    frame(26'h0, 8);
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], 1'b1};
      frame(26'(v), 8);
    end
    for (int i = 0; i < 8; i++) begin
      v = v & (v - 8'h01);
      frame(26'(v), 8);
    end
    chk("fill_locked", 32'(locked), 32'd1);
    chk("fill_mode", 32'(mode_out), 32'd1);
    chk("fill_err_count", 32'(err_count), 32'd2);

    // Mid-stream reset, then symmetric pattern twice.
    do_reset();
    chk("rst2_err_count", 32'(err_count), 32'd0);
    chk("rst2_mode", 32'(mode_out), 32'd0);
    frame(26'h0, 3);
    for (int r = 0; r < 2; r++) begin
      frame(26'h81, 4); frame(26'hC3, 4); frame(26'hE7, 4); frame(26'hFF, 4);
      frame(26'h7E, 4); frame(26'h3C, 4); frame(26'h18, 4); frame(26'h00, 4);
    end
    chk("sym_locked", 32'(locked), 32'd1);
    chk("sym_mode", 32'(mode_out), 32'd2);
    chk("sym_err_count", 32'(err_count), 32'd0);

    // Random one-hot frames with 3-cycle stalls at 26'h1.
    do_reset();
    onehot = '{26'd1 << 3, 26'd1 << 20, 26'd1, 26'd1 << 7, 26'd1 << 25, 26'd1 << 12,
               26'd1, 26'd1 << 1, 26'd1 << 16, 26'd1, 26'd1 << 9};
    holds  = '{1, 1, 4, 1, 1, 1, 4, 1, 1, 4, 1};
    for (int i = 0; i < 11; i++) frame(onehot[i], holds[i]);
    chk("rnd_locked", 32'(locked), 32'd1);
    chk("rnd_mode", 32'(mode_out), 32'd3);
    chk("rnd_err_count", 32'(err_count), 32'd0);
    frame(26'd1, 20);
    chk("rnd_stall_locked", 32'(locked), 32'd1);
    chk("rnd_stall_no_err", 32'(err_count), 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
